// File: rtl/add_arb_pkg.sv
// Shared definitions for the add_arbiter slice: operand width, response-register
// state encoding and helpers to access one requester's slice of a packed operand bus.
package add_arb_pkg;

    localparam int NREQ_DEFAULT = 4;
    localparam int NREQ_MAX     = 8;
    localparam int OPW          = 32;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Callers zero-extend their NREQ*OPW bus to the maximum requester count first.
    function automatic logic [OPW-1:0] op_slice(input logic [NREQ_MAX*OPW-1:0] vec,
                                                input int unsigned idx);
        return vec[idx*OPW +: OPW];
    endfunction

    function automatic logic [NREQ_MAX*OPW-1:0] op_pack(input logic [NREQ_MAX*OPW-1:0] vec,
                                                        input int unsigned idx,
                                                        input logic [OPW-1:0] val);
        logic [NREQ_MAX*OPW-1:0] res;
        res = vec;
        res[idx*OPW +: OPW] = val;
        return res;
    endfunction

endpackage

// File: rtl/csadder.sv
// 32-bit carry-select adder: 4-bit blocks precompute both carry-in cases and the
// incoming block carry selects between them.
module csadder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    localparam int BW = 4;
    localparam int NB = 32 / BW;

    logic [NB:0] carry_s;

    assign carry_s[0] = cin;

    for (genvar i = 0; i < NB; i++) begin : g_blk
        logic [BW:0] sum0_s;
        logic [BW:0] sum1_s;
        assign sum0_s = {1'b0, a[i*BW +: BW]} + {1'b0, b[i*BW +: BW]};
        assign sum1_s = {1'b0, a[i*BW +: BW]} + {1'b0, b[i*BW +: BW]} + 5'd1;
        assign s[i*BW +: BW] = carry_s[i] ? sum1_s[BW-1:0] : sum0_s[BW-1:0];
        assign carry_s[i+1]  = carry_s[i] ? sum1_s[BW]     : sum0_s[BW];
    end

    assign cout = carry_s[NB];

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: lowest asserted request at or after ptr, wrapping.
// Produces a one-hot grant (zero when nothing requests) and its encoded index.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx
);

    // Scan candidates starting at the pointer; the first hit wins.
    always_comb begin
        logic found_s;
        int   cand_s;
        gnt     = '0;
        gnt_idx = '0;
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 0; k < NREQ; k++) begin
            cand_s = int'(ptr) + k;
            if (cand_s >= NREQ) begin
                cand_s = cand_s - NREQ;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s]) begin
                found_s      = 1'b1;
                gnt[cand_s]  = 1'b1;
                gnt_idx      = IDW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin sharing of one carry-select adder among NREQ requesters with a
// single-entry response register. Define ADD_ARBITER_SUB_EN to add per-requester subtract.
module add_arbiter
    import add_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEFAULT,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
    input  logic [NREQ-1:0]     req_cin,
`ifdef ADD_ARBITER_SUB_EN
    input  logic [NREQ-1:0]     req_sub,
`endif
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [OPW-1:0]      rsp_s,
    output logic                rsp_cout,
    output logic                rsp_ov
);

    state_e                    state_r;
    logic [IDW-1:0]            ptr_r;
    logic [IDW-1:0]            rsp_id_r;
    logic [OPW-1:0]            rsp_s_r;
    logic                      rsp_cout_r;
    logic                      rsp_ov_r;

    logic [NREQ-1:0]           gnt_s;
    logic [IDW-1:0]            gnt_idx_s;
    logic                      can_accept_s;
    logic                      xfer_s;
    logic [NREQ_MAX*OPW-1:0]   a_ext_s;
    logic [NREQ_MAX*OPW-1:0]   b_ext_s;
    logic [OPW-1:0]            a_sel_s;
    logic [OPW-1:0]            b_sel_s;
    logic [OPW-1:0]            b_eff_s;
    logic                      cin_eff_s;
    logic [OPW-1:0]            sum_s;
    logic                      cout_s;
    logic                      ov_s;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr (
        .req     (req_valid),
        .ptr     (ptr_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Grant is computed from req_valid only, so req_ready never feeds back into it.
    always_comb begin
        can_accept_s = (state_r == EMPTY) || rsp_ready;
        if (can_accept_s && !rst) begin
            req_ready = gnt_s;
        end else begin
            req_ready = '0;
        end
        xfer_s = |req_ready;
    end

    // Operand mux from the granted requester, with optional subtract inversion.
    always_comb begin
        a_ext_s                 = '0;
        b_ext_s                 = '0;
        a_ext_s[NREQ*OPW-1:0]   = req_a;
        b_ext_s[NREQ*OPW-1:0]   = req_b;
        a_sel_s                 = op_slice(a_ext_s, 32'(gnt_idx_s));
        b_sel_s                 = op_slice(b_ext_s, 32'(gnt_idx_s));
`ifdef ADD_ARBITER_SUB_EN
        if (req_sub[gnt_idx_s]) begin
            b_eff_s   = ~b_sel_s;
            cin_eff_s = 1'b1;
        end else begin
            b_eff_s   = b_sel_s;
            cin_eff_s = req_cin[gnt_idx_s];
        end
`else
        b_eff_s   = b_sel_s;
        cin_eff_s = req_cin[gnt_idx_s];
`endif
    end

    csadder u_add (
        .a    (a_sel_s),
        .b    (b_eff_s),
        .cin  (cin_eff_s),
        .s    (sum_s),
        .cout (cout_s)
    );

    assign ov_s = (a_sel_s[OPW-1] == b_eff_s[OPW-1]) && (sum_s[OPW-1] != a_sel_s[OPW-1]);

    // Response register, FSM and round-robin pointer; fields hold while empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= EMPTY;
            ptr_r      <= '0;
            rsp_id_r   <= '0;
            rsp_s_r    <= '0;
            rsp_cout_r <= 1'b0;
            rsp_ov_r   <= 1'b0;
        end else if (xfer_s) begin
            state_r    <= FULL;
            rsp_id_r   <= gnt_idx_s;
            rsp_s_r    <= sum_s;
            rsp_cout_r <= cout_s;
            rsp_ov_r   <= ov_s;
            if (gnt_idx_s == IDW'(NREQ - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= gnt_idx_s + IDW'(1);
            end
        end else if ((state_r == FULL) && rsp_ready) begin
            state_r <= EMPTY;
        end else begin
            state_r <= state_r;
        end
    end

    assign rsp_valid = (state_r == FULL);
    assign rsp_id    = rsp_id_r;
    assign rsp_s     = rsp_s_r;
    assign rsp_cout  = rsp_cout_r;
    assign rsp_ov    = rsp_ov_r;

endmodule

// File: tb/tb_add_arbiter.sv
// Self-checking bench for add_arbiter: directed scenarios then random traffic,
// compared against a cycle-level behavioural model of the arbitration and arithmetic.
module tb_add_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_a;
    logic [N*W-1:0]  req_b;
    logic [N-1:0]    req_cin;
    logic [N-1:0]    req_sub;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_s;
    logic            rsp_cout;
    logic            rsp_ov;

    int errors = 0;
    int checks = 0;

    // model state
    int          m_ptr;
    bit          m_full;
    logic [1:0]  m_id;
    logic [31:0] m_s;
    logic        m_cout;
    logic        m_ov;
    int          last_grant;

    always #5 clk = ~clk;

    add_arbiter #(.NREQ(N), .IDW(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
`ifdef ADD_ARBITER_SUB_EN
        .req_sub   (req_sub),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout),
        .rsp_ov    (rsp_ov)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic sb);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
        req_cin[i]      = c;
        req_sub[i]      = sb;
    endtask

    task automatic check_rsp();
        chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
        chk("rsp_id",    64'(rsp_id),    64'(m_id));
        chk("rsp_s",     64'(rsp_s),     64'(m_s));
        chk("rsp_cout",  64'(rsp_cout),  64'(m_cout));
        chk("rsp_ov",    64'(rsp_ov),    64'(m_ov));
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        #1;
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst    = 1'b0;
        m_ptr  = 0;
        m_full = 1'b0;
        m_id   = 2'd0;
        m_s    = 32'd0;
        m_cout = 1'b0;
        m_ov   = 1'b0;
        check_rsp();
    endtask

    // One clock: drive handshake inputs, check req_ready, clock, update model, check response.
    task automatic cycle(input logic [N-1:0] v, input logic rr);
        int          g;
        bit          acc;
        logic [31:0] a, b;
        logic        c;
        logic [32:0] full;
        logic [N-1:0] exp_ready;
        req_valid = v;
        rsp_ready = rr;
        #1;
        g = -1;
        acc = !m_full || rr;
        for (int k = 0; k < N; k++) begin
            if (g < 0 && v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        exp_ready = '0;
        if (acc && g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        @(posedge clk); #1;
        last_grant = -1;
        if (acc && g >= 0) begin
            a = req_a[g*W +: W];
            b = req_b[g*W +: W];
            c = req_cin[g];
`ifdef ADD_ARBITER_SUB_EN
            if (req_sub[g]) begin
                b = ~b;
                c = 1'b1;
            end
`endif
            full   = {1'b0, a} + {1'b0, b} + 33'(c);
            m_s    = full[31:0];
            m_cout = full[32];
            m_ov   = (a[31] == b[31]) && (full[31] != a[31]);
            m_id   = 2'(g);
            m_full = 1'b1;
            m_ptr  = (g + 1) % N;
            last_grant = g;
        end else if (m_full && rr) begin
            m_full = 1'b0;
        end
        check_rsp();
    endtask

    initial begin
        logic [31:0] held_s;
        logic [1:0]  held_id;
        req_a = '0; req_b = '0; req_cin = '0; req_sub = '0;
        last_grant = -1;
        do_reset();

        // single request from requester 2
        set_op(2, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        cycle(4'b0100, 1'b1);
        chk("single_id",   64'(rsp_id),   64'd2);
        chk("single_s",    64'(rsp_s),    64'd0);
        chk("single_cout", 64'(rsp_cout), 64'd1);
        chk("single_ov",   64'(rsp_ov),   64'd0);
        cycle(4'b0000, 1'b1);

        // fairness: everyone requesting, consumer always ready; pointer now at 3
        for (int i = 0; i < N; i++) set_op(i, 32'(i * 16 + 1), 32'(i), 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(4'b1111, 1'b1);
            chk("fair_order", 64'(rsp_id), 64'((3 + i) % N));
        end

        // backpressure: response held, no grants, then release
        held_s  = rsp_s;
        held_id = rsp_id;
        for (int i = 0; i < 3; i++) begin
            cycle(4'b1111, 1'b0);
            chk("bp_hold_s",  64'(rsp_s),  64'(held_s));
            chk("bp_hold_id", 64'(rsp_id), 64'(held_id));
        end
        cycle(4'b1111, 1'b1);
        chk("bp_resume_id", 64'(rsp_id), 64'((held_id + 2'd1) % N));
        cycle(4'b0000, 1'b1);
        cycle(4'b0000, 1'b1);

        // signed overflow corner cases
        set_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        set_op(1, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        cycle(4'b0011, 1'b1);
        cycle(4'b0011, 1'b1);
        cycle(4'b0011, 1'b1);
        cycle(4'b0000, 1'b1);

        // reset while a result is held, then requests 1 and 3
        cycle(4'b0100, 1'b0);
        do_reset();
        cycle(4'b1010, 1'b0);
        chk("post_reset_id", 64'(rsp_id), 64'd1);
        cycle(4'b1010, 1'b1);
        chk("post_reset_next", 64'(rsp_id), 64'd3);
        cycle(4'b0000, 1'b1);

`ifdef ADD_ARBITER_SUB_EN
        set_op(0, 32'd5, 32'd7, 1'b0, 1'b1);
        cycle(4'b0001, 1'b1);
        chk("sub_s",    64'(rsp_s),    64'hFFFF_FFFE);
        chk("sub_cout", 64'(rsp_cout), 64'd0);
        chk("sub_ov",   64'(rsp_ov),   64'd0);
        cycle(4'b0000, 1'b1);
`endif

        // random traffic
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                logic [31:0] ra, rb;
                ra = $urandom;
                rb = $urandom;
                if ($urandom_range(0, 7) == 0) ra = 32'h7FFF_FFFF;
                if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
                set_op(i, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 49) == 0) begin
                do_reset();
            end else begin
                cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
